// File: rtl/sequence_checker.sv
`default_nettype none
// ============================================================================
//  Module      : sequence_checker
//  Description : Locks onto the repeating 8-byte period AF BC E2 78 FF E2 0B 8D,
//                flags mismatches and counts errors and verified periods.
//  Revision    : 1.0  initial release
// ============================================================================
module sequence_checker #(
  parameter int LOCK_COUNT = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [7:0]       data,
  input  logic             clear,
  output logic             locked,
  output logic             error,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] frame_count,
  output logic [2:0]       exp_idx
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0]       SYNC_BYTE  = 8'hAF;
  localparam logic [7:0]       LOCK_CNT8  = 8'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_q, state_d;
  logic [2:0]       exp_idx_q, exp_idx_d;
  logic [7:0]       run_cnt_q, run_cnt_d;
  logic             locked_q, locked_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [CNT_W-1:0] frame_count_q, frame_count_d;
  logic [7:0]       exp_byte;
  logic             match;

  always_comb begin
    exp_byte = 8'hAF;
    case (exp_idx_q)
      3'd0: exp_byte = 8'hAF;
      3'd1: exp_byte = 8'hBC;
      3'd2: exp_byte = 8'hE2;
      3'd3: exp_byte = 8'h78;
      3'd4: exp_byte = 8'hFF;
      3'd5: exp_byte = 8'hE2;
      3'd6: exp_byte = 8'h0B;
      3'd7: exp_byte = 8'h8D;
      default: exp_byte = 8'hAF;
    endcase
  end

  assign match = (data == exp_byte);

  always_comb begin
    state_d       = state_q;
    exp_idx_d     = exp_idx_q;
    run_cnt_d     = run_cnt_q;
    error_d       = 1'b0;
    err_count_d   = err_count_q;
    frame_count_d = frame_count_q;

    if (valid) begin
      if (state_q == HUNT) begin
        if (data == SYNC_BYTE) begin
          exp_idx_d = 3'd1;
          run_cnt_d = 8'd1;
          state_d   = (run_cnt_d >= LOCK_CNT8) ? LOCKED : CHECK;
        end
      end else if (match) begin
        exp_idx_d = exp_idx_q + 3'd1;
        run_cnt_d = (run_cnt_q == 8'hFF) ? run_cnt_q : run_cnt_q + 8'd1;
        if (state_q == CHECK && run_cnt_d >= LOCK_CNT8) begin
          state_d = LOCKED;
        end
        // Only a period whose closing byte arrives while already locked counts.
        if (state_q == LOCKED && exp_idx_q == 3'd7) begin
          frame_count_d = frame_count_q + CNT_ONE;
        end
      end else begin
        error_d     = 1'b1;
        err_count_d = (&err_count_q) ? err_count_q : err_count_q + CNT_ONE;
        if (data == SYNC_BYTE) begin
          exp_idx_d = 3'd1;
          run_cnt_d = 8'd1;
          state_d   = (run_cnt_d >= LOCK_CNT8) ? LOCKED : CHECK;
        end else begin
          exp_idx_d = 3'd0;
          run_cnt_d = 8'd0;
          state_d   = HUNT;
        end
      end
    end

    if (clear) begin
      err_count_d   = '0;
      frame_count_d = '0;
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= HUNT;
      exp_idx_q     <= 3'd0;
      run_cnt_q     <= 8'd0;
      locked_q      <= 1'b0;
      error_q       <= 1'b0;
      err_count_q   <= '0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      exp_idx_q     <= exp_idx_d;
      run_cnt_q     <= run_cnt_d;
      locked_q      <= locked_d;
      error_q       <= error_d;
      err_count_q   <= err_count_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign locked      = locked_q;
  assign error       = error_q;
  assign err_count   = err_count_q;
  assign frame_count = frame_count_q;
  assign exp_idx     = exp_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_sequence_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sequence_checker
//  Description : Scoreboard bench for sequence_checker against a reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sequence_checker;

  localparam int LOCK_COUNT = 8;
  localparam int CNT_W      = 4;

  logic             clk = 1'b0;
  logic             reset, valid, clear;
  logic [7:0]       data;
  logic             locked, error;
  logic [CNT_W-1:0] err_count, frame_count;
  logic [2:0]       exp_idx;

  sequence_checker #(.LOCK_COUNT(LOCK_COUNT), .CNT_W(CNT_W)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .valid       (valid),
    .data        (data),
    .clear       (clear),
    .locked      (locked),
    .error       (error),
    .err_count   (err_count),
    .frame_count (frame_count),
    .exp_idx     (exp_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             locked;
    logic             error;
    logic [CNT_W-1:0] errc;
    logic [CNT_W-1:0] frm;
    logic [2:0]       idx;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [7:0] seq_tab [8] = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D};

  // Reference model: 0=HUNT 1=CHECK 2=LOCKED
  int               m_state;
  int               m_idx, m_run;
  logic             m_locked, m_err;
  logic [CNT_W-1:0] m_errc, m_frm;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, expv, $time);
  endtask

  task automatic model(input logic r, input logic v, input logic [7:0] d, input logic c);
    if (r) begin
      m_state = 0; m_idx = 0; m_run = 0;
      m_locked = 0; m_err = 0; m_errc = '0; m_frm = '0;
    end else begin
      m_err = 0;
      if (v) begin
        if (m_state == 0) begin
          if (d == 8'hAF) begin m_state = 1; m_idx = 1; m_run = 1; end
        end else if (d == seq_tab[m_idx]) begin
          if (m_state == 2 && m_idx == 7) m_frm = m_frm + 1'b1;
          m_idx = (m_idx + 1) % 8;
          if (m_run < 255) m_run = m_run + 1;
          if (m_state == 1 && m_run >= LOCK_COUNT) m_state = 2;
        end else begin
          m_err = 1;
          if (m_errc != {CNT_W{1'b1}}) m_errc = m_errc + 1'b1;
          if (d == 8'hAF) begin m_state = 1; m_idx = 1; m_run = 1; end
          else begin m_state = 0; m_idx = 0; m_run = 0; end
        end
      end
      if (c) begin m_errc = '0; m_frm = '0; end
      m_locked = (m_state == 2);
    end
    sb.push_back('{m_locked, m_err, m_errc, m_frm, 3'(m_idx)});
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] d, input logic c);
    exp_t e;
    @(negedge clk);
    reset = r; valid = v; data = d; clear = c;
    model(r, v, d, c);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("locked",      32'(locked),      32'(e.locked));
    check("error",       32'(error),       32'(e.error));
    check("err_count",   32'(err_count),   32'(e.errc));
    check("frame_count", 32'(frame_count), 32'(e.frm));
    check("exp_idx",     32'(exp_idx),     32'(e.idx));
  endtask

  task automatic send(input logic [7:0] d);
    step(1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic send_period(input int start, input int n);
    for (int i = 0; i < n; i++) send(seq_tab[(start + i) % 8]);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    int gen;
    reset = 1'b1; valid = 1'b0; data = 8'h00; clear = 1'b0;

    // Reset state
    do_reset();
    do_reset();
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_errc",   32'(err_count), 32'd0);

    // Clean acquisition: lock after the 8th sample, one frame after the second 8D
    send_period(0, 7);
    check("pre_lock", 32'(locked), 32'd0);
    send(8'h8D);
    check("lock_after_8", 32'(locked), 32'd1);
    send_period(0, 8);
    check("frame_one", 32'(frame_count), 32'd1);
    check("no_errors", 32'(err_count), 32'd0);

    // FF replaced by 00 while locked, then re-acquire at the next AF
    send_period(0, 4);
    send(8'h00);
    check("err_pulse", 32'(error), 32'd1);
    check("unlock",    32'(locked), 32'd0);
    check("hunt_idx",  32'(exp_idx), 32'd0);
    send_period(5, 3);
    check("hunt_quiet", 32'(err_count), 32'd1);
    send_period(0, 8);
    check("relock", 32'(locked), 32'd1);

    // Stream starting mid-period at 78
    do_reset();
    send_period(3, 5);
    check("mid_no_err", 32'(err_count), 32'd0);
    send_period(0, 8);
    check("mid_lock", 32'(locked), 32'd1);

    // valid toggling every cycle
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(seq_tab[i]);
      step(1'b0, 1'b0, 8'h5A, 1'b0);
    end
    check("toggle_lock", 32'(locked), 32'd1);

    // err_count saturation and clear priority; repeated AF mismatches resync each time
    do_reset();
    send(8'hAF);
    for (int i = 0; i < 16; i++) send(8'hAF);
    check("sat_all_ones", 32'(err_count), 32'hF);
    send(8'hAF);
    check("sat_hold", 32'(err_count), 32'hF);
    step(1'b0, 1'b1, 8'hAF, 1'b1);
    check("clr_wins", 32'(err_count), 32'd0);
    check("clr_err",  32'(error), 32'd1);

    // Reset after E2(idx5) while locked, then 0B must be ignored
    do_reset();
    send_period(0, 8);
    send_period(0, 6);
    do_reset();
    check("midrst_locked", 32'(locked), 32'd0);
    send(8'h0B);
    check("midrst_noerr", 32'(error), 32'd0);

    // Random traffic: idle cycles, corruptions, clears, occasional reset
    gen = 0;
    for (int i = 0; i < 600; i++) begin
      logic       v, c, r;
      logic [7:0] d;
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 39) == 0);
      r = ($urandom_range(0, 149) == 0);
      d = seq_tab[gen];
      if ($urandom_range(0, 19) == 0) d = ($urandom_range(0, 1) != 0) ? 8'hAF : 8'($urandom);
      if (v) gen = (gen + 1) % 8;
      step(r, v, d, c);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sequence_checker.md
SEQUENCE_CHECKER -- requirements
Module: sequence_checker

Interface
REQ-001 Parameter LOCK_COUNT, default 8, meaning consecutive matching samples required before locked asserts (legal range 1..255).
REQ-002 Parameter CNT_W, default 16, meaning width of err_count and frame_count.
REQ-003 clk  input  1  rising-edge clock; the block's only clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 valid  input  1  qualifies data; driven by the upstream generator's enable.
REQ-006 data  input  8  upstream sequence byte, sampled only when valid=1.
REQ-007 clear  input  1  synchronous clear of err_count and frame_count.
REQ-008 locked  output  1  registered; high while the stream is tracked and verified.
REQ-009 error  output  1  registered one-cycle pulse per mismatching sample.
REQ-010 err_count  output  CNT_W  registered mismatch count, saturating.
REQ-011 frame_count  output  CNT_W  registered count of complete verified periods, wrapping.
REQ-012 exp_idx  output  3  registered index of the next expected byte; debug only.

Function
REQ-013 Expected period: idx0..7 = AF, BC, E2, 78, FF, E2, 0B, 8D; after idx7 the sequence wraps to idx0.
REQ-014 States: HUNT, CHECK, LOCKED; a run counter run_cnt (8 bits) counts consecutive matches.
REQ-015 Samples with valid=0 leave state, index, counters and outputs unchanged; error reads 0 on those cycles.
REQ-016 HUNT, valid, data=AF: go to CHECK with exp_idx=1 and run_cnt=1; any other byte is ignored and raises no error.
REQ-017 CHECK/LOCKED, valid, data=expected[exp_idx]: exp_idx increments mod 8 and run_cnt increments, saturating at 255.
REQ-018 CHECK moves to LOCKED on the cycle run_cnt reaches LOCK_COUNT; locked reads 1 from the following cycle.
REQ-019 CHECK/LOCKED, valid, mismatch:
- error=1 for exactly one cycle after the sample;
- err_count increments, holding at all-ones;
- locked clears on the next cycle.
REQ-020 Mismatch with data=AF: resync to CHECK with exp_idx=1 and run_cnt=1. Any other mismatching byte: go to HUNT with exp_idx=0 and run_cnt=0.
REQ-021 frame_count increments, wrapping, on each matching 8D sample accepted while in LOCKED.
REQ-022 Duplicate E2 (idx2, idx5) is resolved by position only; lock acquisition starts only at AF.
REQ-023 clear=1 zeroes err_count and frame_count next cycle; clear wins over a simultaneous increment; state, exp_idx and locked are unaffected.
REQ-024 All outputs are registered; latency from the sampled input to its output effect is one cycle.

Reset
REQ-025 reset=1 at a clk edge sets:
- state HUNT, exp_idx=0, run_cnt=0;
- locked=0, error=0;
- err_count=0, frame_count=0.
REQ-026 reset overrides valid and clear; asserting it mid-period discards the partial period with no error pulse.
REQ-027 Outputs are undefined only before the first reset edge; no asynchronous behaviour exists.

Verification
REQ-028 Reset, then 16 valid cycles of the correct period starting at AF -> locked=1 one cycle after the 8th sample; frame_count=1 after the second 8D; error never asserts.
REQ-029 While locked, replace the FF byte with 00 -> error pulses once; err_count=1; locked=0 next cycle; state HUNT; the following AF re-acquires and locked=1 after 8 more matches.
REQ-030 Start the stream at 78 (mid-period) -> no errors until the first AF; lock occurs 8 valid samples after that AF.
REQ-031 Toggle valid 1/0 every cycle during a correct stream -> lock occurs after 8 valid samples (16 cycles); the idle cycles cause no state change.
REQ-032 Force err_count to all-ones, inject a mismatch with clear=0 -> count holds; inject a mismatch with clear=1 -> err_count=0 and error still pulses.
REQ-033 Assert reset after sample E2(idx5) while locked -> all outputs at reset values next cycle; a subsequent 0B raises no error (HUNT).
